// File: rtl/alu_arbiter_pkg.sv
// Types and constants shared by the ALU arbiter and its round-robin grant logic.
// No latency: declarations only.
// No flow control: declarations only.
package alu_arbiter_pkg;

   // ALU command encodings; mirrored by the `ALU_CMD_* macros.
   localparam int CMD_W = 3;
   localparam logic [CMD_W-1:0] CMD_ADD  = 3'd0;
   localparam logic [CMD_W-1:0] CMD_SUB  = 3'd1;
   localparam logic [CMD_W-1:0] CMD_XOR  = 3'd2;
   localparam logic [CMD_W-1:0] CMD_SLT  = 3'd3;
   localparam logic [CMD_W-1:0] CMD_AND  = 3'd4;
   localparam logic [CMD_W-1:0] CMD_NAND = 3'd5;
   localparam logic [CMD_W-1:0] CMD_NOR  = 3'd6;
   localparam logic [CMD_W-1:0] CMD_OR   = 3'd7;

   // Settle counter width; SETTLE_CYCLES is limited to 1..15.
   localparam int CNT_W = 4;

   // FSM states; mirrored by the `ALU_ST_* macros.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Counter preload for a given settle time (counts down to zero).
   function automatic logic [CNT_W-1:0] settle_preload(input int settle);
      return CNT_W'(settle - 1);
   endfunction

endpackage

// File: rtl/alu_arbiter_defs.sv
// Shared ALU command and arbiter FSM state encodings for the ALU bench and control unit.
// No logic: macro definitions only, guarded against double inclusion.
// Values must stay in step with the localparams in alu_arbiter_pkg.
`ifndef ALU_ARBITER_DEFS_SV
`define ALU_ARBITER_DEFS_SV

`define ALU_CMD_ADD  3'd0
`define ALU_CMD_SUB  3'd1
`define ALU_CMD_XOR  3'd2
`define ALU_CMD_SLT  3'd3
`define ALU_CMD_AND  3'd4
`define ALU_CMD_NAND 3'd5
`define ALU_CMD_NOR  3'd6
`define ALU_CMD_OR   3'd7

`define ALU_ST_IDLE  2'd0
`define ALU_ST_EXEC  2'd1
`define ALU_ST_RESP  2'd2

`endif

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: one-hot grant, the port not granted last wins a tie.
// Latency: purely combinational.
// Backpressure: en=0 forces the grant to zero.
module rr_arbiter_2 (
   input  logic       vld0,
   input  logic       vld1,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] gnt
);

   // Grant the sole requester, or on a tie the port other than ptr.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (vld0 && vld1) begin
            gnt = ptr ? 2'b01 : 2'b10;
         end else if (vld0) begin
            gnt = 2'b01;
         end else if (vld1) begin
            gnt = 2'b10;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, round-robin.
// Latency: accept in cycle T gives rsp_valid in cycle T+SETTLE_CYCLES+1.
// Backpressure: one op in flight; no ready until the response is taken.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2    // 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_cmd,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_cmd,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cmd,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carryout,
   output logic             rsp_zero,
   output logic             rsp_overflow
);

   localparam logic [CNT_W-1:0] CNT_INIT = settle_preload(SETTLE_CYCLES);

   state_t           state_q;
   state_t           state_d;
   logic             ptr_q;       // last granted port
   logic             live_q;      // rst_n has been high for at least one edge
   logic [CNT_W-1:0] cnt_q;
   logic             id_q;
   logic [1:0]       gnt;
   logic             arb_en;
   logic             load;
   logic             capture;

   // Grants are only offered in IDLE, and never on the first edge after reset.
   assign arb_en = (state_q == ST_IDLE) && live_q;

   rr_arbiter_2 u_rr (
      .vld0 (req0_valid),
      .vld1 (req1_valid),
      .ptr  (ptr_q),
      .en   (arb_en),
      .gnt  (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the accept/capture strobes.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A grant is only raised for a valid port, so any grant is a handshake.
            if (gnt != 2'b00) begin
               load    = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Post-reset gate: keeps ready low until the first edge with rst_n high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
      end
   end

   // Round-robin pointer and requester id follow each accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b1;
         id_q  <= 1'b0;
      end else if (load) begin
         ptr_q <= gnt[1];
         id_q  <= gnt[1];
      end
   end

   // Settle counter: preload on accept, count down to zero in EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CNT_INIT;
      end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // ALU operand registers: loaded from the granted port, held until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_cmd <= '0;
      end else if (load) begin
         alu_a   <= gnt[1] ? req1_a   : req0_a;
         alu_b   <= gnt[1] ? req1_b   : req0_b;
         alu_cmd <= gnt[1] ? req1_cmd : req0_cmd;
      end
   end

   // Response payload: sampled once from the ALU when the settle time expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else if (capture) begin
         rsp_id       <= id_q;
         rsp_result   <= alu_result;
         rsp_carryout <= alu_carryout;
         rsp_zero     <= alu_zero;
         rsp_overflow <= alu_overflow;
      end
   end

   // Response valid: set on capture, cleared by the consumer handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
      end else if (capture) begin
         rsp_valid <= 1'b1;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences and shares one combinational 32-bit ALU between two requesters (port 0, port 1).
- Accepts operations with a valid/ready handshake and grants round-robin.
- Holds the granted operands on the ALU inputs for a programmable settle time, then captures the result and flags into a response register.
- Sits between the register-file/control logic and the ALU; the ALU itself stays outside this block.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture (1..15); covers gate-delay ripple through the adder chain.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  port 0 has an operation
req0_ready  output  1  port 0 operation accepted this cycle
req0_a  input  WIDTH  port 0 operand A
req0_b  input  WIDTH  port 0 operand B
req0_cmd  input  3  port 0 ALU command
req1_valid, req1_ready, req1_a, req1_b, req1_cmd  same as port 0, for port 1
alu_a  output  WIDTH  registered operand A to the ALU
alu_b  output  WIDTH  registered operand B to the ALU
alu_cmd  output  3  registered command to the ALU
alu_result  input  WIDTH  ALU result
alu_carryout  input  1  ALU carry out
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  requester that issued the operation (0/1)
rsp_result  output  WIDTH  captured result
rsp_carryout, rsp_zero, rsp_overflow  output  1 each  captured flags

Behaviour:
- Command encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
  - All eight are legal and are passed through unmodified.
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Last-grant pointer = 1, so port 0 wins the first tie.
  - Settle counter = 0.
- FSM IDLE:
  - Grant is combinational.
  - One valid: that port is granted.
  - Both valid: grant the port that was not granted last.
  - reqN_ready = grant for N while in IDLE; 0 in every other state.
  - Never both high in the same cycle.
  - On handshake (valid & ready), register a/b/cmd onto alu_a/alu_b/alu_cmd and register the port id.
  - Update the pointer to that port, load counter = SETTLE_CYCLES-1, go to EXEC.
- FSM EXEC:
  - alu_* stay constant.
  - Counter nonzero: decrement.
  - Counter zero: capture alu_result and the three flags into rsp_*, set rsp_valid=1, go to RESP.
- FSM RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid and go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake; there is no overlap.
  - alu_* keep their last value until the next accept.
- Latency:
  - Handshake in cycle T gives rsp_valid=1 in cycle T+SETTLE_CYCLES+1.
  - Throughput is one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held at 1.
- Requester rule: a, b and cmd must be held while valid=1 and ready=0. A valid that drops before acceptance is not an error; nothing is issued.
- Starvation: with both ports continuously valid, grants strictly alternate 0,1,0,1.
- Flags: no recomputation. rsp_zero, rsp_carryout and rsp_overflow are exactly the ALU values sampled at capture.
- Reset mid-operation (EXEC or RESP):
  - The operation and any pending response are dropped and rsp_valid clears immediately.
  - No ready is issued until rst_n has been high for one edge.

Decomposition:
- Shared include file: the ALU command `define constants (ADD..OR) and the FSM state encodings IDLE=0, EXEC=1, RESP=2. These are also used by the ALU bench and the future control unit.
- One sub-module: rr_arbiter_2.
  - Inputs: two valid inputs, pointer, enable.
  - Outputs: one-hot grant.
  - Purely combinational.
  - The pointer register lives in alu_arbiter.

Test Plan:
- Single op: port 0 ADD a=5, b=7 with SETTLE_CYCLES=2 -> rsp_valid at T+3, rsp_result=12, rsp_id=0, rsp_zero=0, carryout=0, overflow=0.
- Tie and fairness: both ports valid continuously, port 0 SUB 10-3, port 1 XOR 0xF0^0xFF, rsp_ready=1 -> grants alternate 0,1,0,1; results 7 and 0x0F; first grant goes to port 0.
- Flags: port 1 ADD 0x7FFFFFFF+1 -> rsp_overflow=1, rsp_result=0x80000000. Then SUB 9-9 -> rsp_zero=1, rsp_result=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* constant; req0_ready and req1_ready stay 0; completes one cycle after rsp_ready rises.
- Reset mid-op: rst_n low during EXEC -> all outputs 0 asynchronously and pointer back to 1. After release, port 0 NOR 0,0 -> result 0xFFFFFFFF.
- Settle parameter: SETTLE_CYCLES=1 with port 0 AND 0xFF00&0x0FF0 -> rsp_valid at T+2, result 0x0F00.
